// File: rtl/psr_cond_unit.sv
// PSR flag register and ARM condition-code evaluator with pass/skip statistics.
module psr_cond_unit #(
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             s_en,
    input  logic [3:0]       cond,
    input  logic             cond_valid,
    input  logic             stall,
    output logic [3:0]       flags,
    output logic             cin,
    output logic             cond_pass,
    output logic             pass_valid,
    output logic             cond_illegal,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam int unsigned FLAG_W = 4;
    localparam logic [3:0]  COND_NV = 4'b1111;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [FLAG_W-1:0] alu_flags_c;
    logic [FLAG_W-1:0] eval_flags_c;
    logic              e_n, e_z, e_c, e_v;
    logic              pass_c;
    logic              illegal_c;

    assign alu_flags_c = {alu_n, alu_z, alu_c, alu_v};

    // Carry to the ALU comes straight from the registered PSR.
    assign cin = flags[1];

    // Select evaluation flags: forwarded ALU flags or the registered PSR.
    always_comb begin
        eval_flags_c = flags;
        if (BYPASS && s_en) begin
            eval_flags_c = alu_flags_c;
        end
    end

    assign e_n       = eval_flags_c[3];
    assign e_z       = eval_flags_c[2];
    assign e_c       = eval_flags_c[1];
    assign e_v       = eval_flags_c[0];
    assign illegal_c = (cond == COND_NV);

    // ARM condition table evaluated on the selected flags.
    always_comb begin
        pass_c = 1'b0;
        case (cond)
            4'b0000: pass_c = e_z;
            4'b0001: pass_c = !e_z;
            4'b0010: pass_c = e_c;
            4'b0011: pass_c = !e_c;
            4'b0100: pass_c = e_n;
            4'b0101: pass_c = !e_n;
            4'b0110: pass_c = e_v;
            4'b0111: pass_c = !e_v;
            4'b1000: pass_c = e_c && !e_z;
            4'b1001: pass_c = !e_c || e_z;
            4'b1010: pass_c = (e_n == e_v);
            4'b1011: pass_c = (e_n != e_v);
            4'b1100: pass_c = !e_z && (e_n == e_v);
            4'b1101: pass_c = e_z || (e_n != e_v);
            4'b1110: pass_c = 1'b1;
            default: pass_c = 1'b0;
        endcase
    end

    // PSR, evaluation result and saturating counters; stall freezes everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags        <= '0;
            cond_pass    <= 1'b0;
            pass_valid   <= 1'b0;
            cond_illegal <= 1'b0;
            exec_cnt     <= '0;
            skip_cnt     <= '0;
        end else if (!stall) begin
            if (s_en) begin
                flags <= alu_flags_c;
            end
            pass_valid   <= cond_valid;
            cond_pass    <= cond_valid && pass_c;
            cond_illegal <= cond_valid && illegal_c;
            if (cond_valid && pass_c && (exec_cnt != CNT_MAX)) begin
                exec_cnt <= exec_cnt + CNT_W'(1);
            end
            if (cond_valid && !pass_c && !illegal_c && (skip_cnt != CNT_MAX)) begin
                skip_cnt <= skip_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_psr_cond_unit.sv
// Directed table-driven bench for psr_cond_unit (bypass, no-bypass and narrow-counter builds).
module tb_psr_cond_unit;

    logic        clk;
    logic        reset_n;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic        s_en;
    logic [3:0]  cond;
    logic        cond_valid;
    logic        stall;

    logic [3:0]  flags,  flags_nb,  flags_sat;
    logic        cin,    cin_nb,    cin_sat;
    logic        pass,   pass_nb,   pass_sat;
    logic        pv,     pv_nb,     pv_sat;
    logic        ill,    ill_nb,    ill_sat;
    logic [15:0] exec_cnt, skip_cnt, exec_nb, skip_nb;
    logic [1:0]  exec_sat, skip_sat;

    int tests = 0;
    int fails = 0;

    psr_cond_unit #(.BYPASS(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .s_en(s_en), .cond(cond), .cond_valid(cond_valid), .stall(stall),
        .flags(flags), .cin(cin), .cond_pass(pass), .pass_valid(pv),
        .cond_illegal(ill), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    psr_cond_unit #(.BYPASS(1'b0), .CNT_W(16)) dut_nb (
        .clk(clk), .reset_n(reset_n),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .s_en(s_en), .cond(cond), .cond_valid(cond_valid), .stall(stall),
        .flags(flags_nb), .cin(cin_nb), .cond_pass(pass_nb), .pass_valid(pv_nb),
        .cond_illegal(ill_nb), .exec_cnt(exec_nb), .skip_cnt(skip_nb)
    );

    psr_cond_unit #(.BYPASS(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .s_en(s_en), .cond(cond), .cond_valid(cond_valid), .stall(stall),
        .flags(flags_sat), .cin(cin_sat), .cond_pass(pass_sat), .pass_valid(pv_sat),
        .cond_illegal(ill_sat), .exec_cnt(exec_sat), .skip_cnt(skip_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s_en;
        logic [3:0]  alu;
        logic [3:0]  cond;
        logic        cv;
        logic        stall;
        logic [3:0]  e_flags;
        logic        e_pass;
        logic        e_valid;
        logic        e_ill;
        logic [15:0] e_exec;
        logic [15:0] e_skip;
        logic        chk_nb;
        logic        nb_pass;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t mk(logic se, logic [3:0] alu, logic [3:0] cd, logic cv, logic st,
                                logic [3:0] ef, logic ep, logic ev, logic ei,
                                logic [15:0] ee, logic [15:0] es, logic cnb, logic nbp);
        vec_t v;
        v.s_en = se; v.alu = alu; v.cond = cd; v.cv = cv; v.stall = st;
        v.e_flags = ef; v.e_pass = ep; v.e_valid = ev; v.e_ill = ei;
        v.e_exec = ee; v.e_skip = es; v.chk_nb = cnb; v.nb_pass = nbp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic se, input logic [3:0] alu, input logic [3:0] cd,
                         input logic cv, input logic st);
        s_en = se;
        {alu_n, alu_z, alu_c, alu_v} = alu;
        cond = cd;
        cond_valid = cv;
        stall = st;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           s_en alu      cond     cv  st   flags   pass vld  ill  exec skip  nb  nbpass
        vecs[0]  = mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 1, 0, 0,  1,  1, 0); // EQ on 0000
        vecs[1]  = mk(0, 4'b0000, 4'b0001, 1, 0, 4'b0000, 1, 1, 0, 1,  1,  0, 0); // NE
        vecs[2]  = mk(1, 4'b1011, 4'b1010, 1, 0, 4'b1011, 1, 1, 0, 2,  1,  1, 1); // GE with write
        vecs[3]  = mk(1, 4'b0110, 4'b1000, 1, 0, 4'b0110, 0, 1, 0, 2,  2,  1, 1); // HI, bypass differs
        vecs[4]  = mk(0, 4'b0000, 4'b1001, 1, 0, 4'b0110, 1, 1, 0, 3,  2,  0, 0); // LS
        vecs[5]  = mk(0, 4'b0000, 4'b1100, 1, 0, 4'b0110, 0, 1, 0, 3,  3,  0, 0); // GT
        vecs[6]  = mk(0, 4'b0000, 4'b1101, 1, 0, 4'b0110, 1, 1, 0, 4,  3,  0, 0); // LE
        vecs[7]  = mk(0, 4'b0000, 4'b1110, 1, 0, 4'b0110, 1, 1, 0, 5,  3,  0, 0); // AL
        vecs[8]  = mk(0, 4'b0000, 4'b1111, 1, 0, 4'b0110, 0, 1, 1, 5,  3,  0, 0); // NV illegal
        vecs[9]  = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0110, 0, 0, 0, 5,  3,  0, 0); // idle
        vecs[10] = mk(0, 4'b0000, 4'b0010, 1, 0, 4'b0110, 1, 1, 0, 6,  3,  0, 0); // CS
        vecs[11] = mk(0, 4'b0000, 4'b0011, 1, 0, 4'b0110, 0, 1, 0, 6,  4,  0, 0); // CC
        vecs[12] = mk(0, 4'b0000, 4'b0100, 1, 0, 4'b0110, 0, 1, 0, 6,  5,  0, 0); // MI
        vecs[13] = mk(0, 4'b0000, 4'b0101, 1, 0, 4'b0110, 1, 1, 0, 7,  5,  0, 0); // PL
        vecs[14] = mk(0, 4'b0000, 4'b0110, 1, 0, 4'b0110, 0, 1, 0, 7,  6,  0, 0); // VS
        vecs[15] = mk(0, 4'b0000, 4'b0111, 1, 0, 4'b0110, 1, 1, 0, 8,  6,  0, 0); // VC
        vecs[16] = mk(0, 4'b0000, 4'b1011, 1, 0, 4'b0110, 0, 1, 0, 8,  7,  0, 0); // LT
        vecs[17] = mk(1, 4'b1000, 4'b0000, 0, 0, 4'b1000, 0, 0, 0, 8,  7,  0, 0); // write only
        vecs[18] = mk(0, 4'b0000, 4'b1011, 1, 0, 4'b1000, 1, 1, 0, 9,  7,  0, 0); // LT N!=V
        vecs[19] = mk(0, 4'b0000, 4'b1010, 1, 0, 4'b1000, 0, 1, 0, 9,  8,  0, 0); // GE
        vecs[20] = mk(1, 4'b0101, 4'b0000, 1, 1, 4'b1000, 0, 1, 0, 9,  8,  0, 0); // stall 1
        vecs[21] = mk(1, 4'b0101, 4'b0000, 1, 1, 4'b1000, 0, 1, 0, 9,  8,  0, 0); // stall 2
        vecs[22] = mk(1, 4'b0101, 4'b0000, 1, 1, 4'b1000, 0, 1, 0, 9,  8,  0, 0); // stall 3
        vecs[23] = mk(1, 4'b0101, 4'b0000, 1, 0, 4'b0101, 1, 1, 0, 10, 8,  1, 0); // released
        vecs[24] = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0101, 0, 0, 0, 10, 8,  0, 0); // once only

        // Reset with busy inputs
        reset_n = 1'b0;
        drive(1, 4'b1111, 4'b1110, 1, 0);
        tick();
        tick();
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_cin", 32'(cin), 32'h0);
        chk("rst_pass", 32'(pass), 32'h0);
        chk("rst_valid", 32'(pv), 32'h0);
        chk("rst_ill", 32'(ill), 32'h0);
        chk("rst_exec", 32'(exec_cnt), 32'h0);
        chk("rst_skip", 32'(skip_cnt), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].s_en, vecs[i].alu, vecs[i].cond, vecs[i].cv, vecs[i].stall);
            tick();
            chk($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].e_flags));
            chk($sformatf("v%0d_cin", i), 32'(cin), 32'(vecs[i].e_flags[1]));
            chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].e_pass));
            chk($sformatf("v%0d_valid", i), 32'(pv), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_ill", i), 32'(ill), 32'(vecs[i].e_ill));
            chk($sformatf("v%0d_exec", i), 32'(exec_cnt), 32'(vecs[i].e_exec));
            chk($sformatf("v%0d_skip", i), 32'(skip_cnt), 32'(vecs[i].e_skip));
            if (vecs[i].chk_nb) begin
                chk($sformatf("v%0d_nb_pass", i), 32'(pass_nb), 32'(vecs[i].nb_pass));
                chk($sformatf("v%0d_nb_flags", i), 32'(flags_nb), 32'(vecs[i].e_flags));
            end
        end

        // Narrow counter saturation
        reset_n = 1'b0;
        drive(0, 4'b0000, 4'b0000, 0, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(0, 4'b0000, 4'b1110, 1, 0);
            tick();
            chk($sformatf("sat%0d_exec", i), 32'(exec_sat), (i > 3) ? 32'd3 : 32'(i));
            chk($sformatf("sat%0d_skip", i), 32'(skip_sat), 32'h0);
            chk($sformatf("sat%0d_pass", i), 32'(pass_sat), 32'h1);
        end

        // Reset mid-stream overrides stall, s_en and cond_valid
        reset_n = 1'b0;
        drive(1, 4'b1111, 4'b1110, 1, 1);
        tick();
        chk("mid_rst_sat_exec", 32'(exec_sat), 32'h0);
        chk("mid_rst_sat_pass", 32'(pass_sat), 32'h0);
        chk("mid_rst_sat_valid", 32'(pv_sat), 32'h0);
        chk("mid_rst_sat_flags", 32'(flags_sat), 32'h0);
        chk("mid_rst_cin", 32'(cin), 32'h0);
        chk("mid_rst_exec", 32'(exec_cnt), 32'h0);
        chk("mid_rst_skip", 32'(skip_cnt), 32'h0);

        // First evaluation after reset sees 0000
        reset_n = 1'b1;
        drive(0, 4'b1111, 4'b0000, 1, 0);
        tick();
        chk("post_rst_eq_pass", 32'(pass), 32'h0);
        chk("post_rst_eq_skip", 32'(skip_cnt), 32'h1);
        chk("post_rst_nb_pass", 32'(pass_nb), 32'h0);
        chk("post_rst_flags", 32'(flags), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
